// File: rtl/memc_arb_pkg.sv
// Shared defaults and FSM state type for the matrix-C memory port arbiter.
package memc_arb_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 256;
    localparam int LEN_W_DEF  = 4;

    // IDLE: memory port quiet. BURST: a beat is presented on the memory port.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/memc_rr_pick.sv
// Two-way round-robin pick. last_i names the requester granted most
// recently; under contention the other one wins, a lone requester always wins.
module memc_rr_pick (
    input  logic [1:0] req_i,
    input  logic       last_i,
    output logic [1:0] grant_o,
    output logic       idx_o
);

    // Combinational winner selection
    always_comb begin
        grant_o = 2'b00;
        idx_o   = 1'b0;
        case (req_i)
            2'b01:   idx_o = 1'b0;
            2'b10:   idx_o = 1'b1;
            2'b11:   idx_o = ~last_i;
            default: idx_o = 1'b0;
        endcase
        if (req_i != 2'b00) begin
            grant_o = idx_o ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/memc_port_arbiter.sv
// Two-requester burst arbiter for the 256-bit matrix-C memory port.
// Optional feature macro MEMC_ARB_STATS_EN adds per-requester beat counters
// (stat_clear, stat_beats0, stat_beats1).
//
// Handshake: a command moves when cmd_valid[i] && cmd_ready[i] in the same
// cycle; cmd_ready is only offered in IDLE or the last-beat cycle of a burst
// and never depends on the requester holding cmd_valid beyond that cycle.
// Write data moves when wdata_ready[i] is high: the requester must present
// beat k in the k-th cycle of the burst starting at the acceptance cycle.
module memc_port_arbiter
    import memc_arb_pkg::*;
#(
    parameter  int ADDR_W = ADDR_W_DEF,
    parameter  int DATA_W = DATA_W_DEF,
    parameter  int LEN_W  = LEN_W_DEF,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic                   clk,
    input  logic                   reset,
`ifdef MEMC_ARB_STATS_EN
    input  logic                   stat_clear,
    output logic [31:0]            stat_beats0,
    output logic [31:0]            stat_beats1,
`endif
    input  logic [1:0]             cmd_valid,
    output logic [1:0]             cmd_ready,
    input  logic [1:0]             cmd_write,
    input  logic [1:0][ADDR_W-1:0] cmd_addr,
    input  logic [1:0][LEN_W-1:0]  cmd_len,
    input  logic [1:0][DATA_W-1:0] wdata,
    input  logic [1:0][BE_W-1:0]   wbe,
    output logic [1:0]             wdata_ready,
    output logic [DATA_W-1:0]      rdata,
    output logic [1:0]             rvalid,
    output logic [ADDR_W-1:0]      mem_address,
    output logic                   mem_chipselect,
    output logic                   mem_write,
    output logic [DATA_W-1:0]      mem_writedata,
    output logic [BE_W-1:0]        mem_byteenable,
    output logic                   mem_clken,
    input  logic [DATA_W-1:0]      mem_readdata,
    output arb_state_e             dbg_state
);

    arb_state_e        state_q, state_d;
    logic              owner_q, owner_d;
    logic              write_q, write_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  pend_q, pend_d;
    logic              last_q, last_d;

    logic [ADDR_W-1:0] mem_address_q;
    logic              mem_cs_q;
    logic              mem_write_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [BE_W-1:0]   mem_be_q;
    logic              mem_clken_q;
    logic              mem_owner_q;
    logic [1:0]        rvalid_q;

    logic [1:0]        pick_gnt;
    logic              pick_idx;
    logic              can_accept;
    logic              accept;
    logic              beat_go;
    logic              beat_owner;
    logic              beat_write;
    logic [ADDR_W-1:0] beat_addr;

    memc_rr_pick u_pick (
        .req_i   (cmd_valid),
        .last_i  (last_q),
        .grant_o (pick_gnt),
        .idx_o   (pick_idx)
    );

    // FSM and burst bookkeeping registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= '0;
            pend_q  <= '0;
            last_q  <= 1'b1;   // requester 0 wins the first contention
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            pend_q  <= pend_d;
            last_q  <= last_d;
        end
    end

    // Next state, acceptance and the beat to register onto the memory port.
    // mem_clken_q doubles as "out of reset for one edge", holding off accepts.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        write_d     = write_q;
        addr_d      = addr_q;
        pend_d      = pend_q;
        last_d      = last_q;
        beat_go     = 1'b0;
        beat_owner  = owner_q;
        beat_write  = write_q;
        beat_addr   = addr_q;
        wdata_ready = 2'b00;

        can_accept = mem_clken_q && ((state_q == ST_IDLE) || (pend_q == '0));
        cmd_ready  = can_accept ? pick_gnt : 2'b00;
        accept     = can_accept && (pick_gnt != 2'b00);

        if (accept) begin
            beat_go    = 1'b1;
            beat_owner = pick_idx;
            beat_write = cmd_write[pick_idx];
            beat_addr  = cmd_addr[pick_idx];
            state_d    = ST_BURST;
            owner_d    = pick_idx;
            write_d    = cmd_write[pick_idx];
            addr_d     = cmd_addr[pick_idx] + ADDR_W'(1);
            pend_d     = cmd_len[pick_idx];
            last_d     = pick_idx;
        end else if (state_q == ST_BURST) begin
            if (pend_q != '0) begin
                beat_go = 1'b1;
                addr_d  = addr_q + ADDR_W'(1);
                pend_d  = pend_q - LEN_W'(1);
            end else begin
                state_d = ST_IDLE;
            end
        end

        if (beat_go && beat_write) begin
            wdata_ready[beat_owner] = 1'b1;
        end
    end

    // Registered memory port and read-return valid pipeline
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_address_q <= '0;
            mem_cs_q      <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_wdata_q   <= '0;
            mem_be_q      <= '0;
            mem_clken_q   <= 1'b0;
            mem_owner_q   <= 1'b0;
            rvalid_q      <= 2'b00;
        end else begin
            mem_clken_q <= 1'b1;
            rvalid_q    <= 2'b00;
            if (mem_cs_q && !mem_write_q) begin
                rvalid_q <= mem_owner_q ? 2'b10 : 2'b01;
            end
            if (beat_go) begin
                mem_cs_q      <= 1'b1;
                mem_write_q   <= beat_write;
                mem_address_q <= beat_addr;
                mem_owner_q   <= beat_owner;
                if (beat_write) begin
                    mem_wdata_q <= wdata[beat_owner];
                    mem_be_q    <= wbe[beat_owner];
                end else begin
                    mem_be_q    <= '1;
                end
            end else begin
                mem_cs_q    <= 1'b0;
                mem_write_q <= 1'b0;
            end
        end
    end

`ifdef MEMC_ARB_STATS_EN
    logic [31:0] stat_beats0_q;
    logic [31:0] stat_beats1_q;

    // Saturating per-requester beat counters; clear beats a same-cycle beat
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_beats0_q <= '0;
            stat_beats1_q <= '0;
        end else if (stat_clear) begin
            stat_beats0_q <= '0;
            stat_beats1_q <= '0;
        end else begin
            if (mem_cs_q && !mem_owner_q && (stat_beats0_q != '1)) begin
                stat_beats0_q <= stat_beats0_q + 32'd1;
            end
            if (mem_cs_q && mem_owner_q && (stat_beats1_q != '1)) begin
                stat_beats1_q <= stat_beats1_q + 32'd1;
            end
        end
    end

    assign stat_beats0 = stat_beats0_q;
    assign stat_beats1 = stat_beats1_q;
`endif

    assign mem_address    = mem_address_q;
    assign mem_chipselect = mem_cs_q;
    assign mem_write      = mem_write_q;
    assign mem_writedata  = mem_wdata_q;
    assign mem_byteenable = mem_be_q;
    assign mem_clken      = mem_clken_q;
    assign rvalid         = rvalid_q;
    assign rdata          = mem_readdata;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_memc_port_arbiter.sv
// Directed testbench for memc_port_arbiter (optionally with MEMC_ARB_STATS_EN).
module tb_memc_port_arbiter;
  import memc_arb_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]         cmd_valid, cmd_ready, cmd_write, wdata_ready, rvalid;
  logic [1:0][10:0]   cmd_addr;
  logic [1:0][3:0]    cmd_len;
  logic [1:0][255:0]  wdata;
  logic [1:0][31:0]   wbe;
  logic [255:0]       rdata, mem_writedata, mem_readdata;
  logic [10:0]        mem_address;
  logic               mem_chipselect, mem_write, mem_clken;
  logic [31:0]        mem_byteenable;
  arb_state_e         dbg_state;
`ifdef MEMC_ARB_STATS_EN
  logic               stat_clear = 1'b0;
  logic [31:0]        stat_beats0, stat_beats1;
`endif

  memc_port_arbiter dut (
    .clk            (clk),
    .reset          (reset),
`ifdef MEMC_ARB_STATS_EN
    .stat_clear     (stat_clear),
    .stat_beats0    (stat_beats0),
    .stat_beats1    (stat_beats1),
`endif
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .wdata          (wdata),
    .wbe            (wbe),
    .wdata_ready    (wdata_ready),
    .rdata          (rdata),
    .rvalid         (rvalid),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_byteenable (mem_byteenable),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .dbg_state      (dbg_state)
  );

  // ---------------- memory model ----------------
  function automatic logic [255:0] rd_pat(input logic [10:0] a);
    return {8{21'h1A5A5, a}};
  endfunction

  function automatic logic [255:0] wd_pat(input int k);
    return {8{32'hC0DE_0000 + 32'(k)}};
  endfunction

  function automatic logic [31:0] be_pat(input int k);
    return {8{4'(k + 3)}};
  endfunction

  logic [255:0] rd_q = '0;
  always @(posedge clk) begin
    if (mem_chipselect && !mem_write) rd_q <= rd_pat(mem_address);
  end
  assign mem_readdata = rd_q;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard for read returns ----------------
  logic [255:0] exp_q[$];

  always @(negedge clk) begin
    if (rvalid != 2'b00) begin
      if (exp_q.size() == 0) begin
        check("rv_unexpected", 256'(rvalid), 256'(0));
      end else begin
        check("rdata", rdata, exp_q.pop_front());
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cmd_valid = 2'b00;
    cmd_write = 2'b00;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  // contention tables, cycles c0..c10
  logic [1:0]  ct_rdy  [11] = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
  logic        ct_cs   [11] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [10:0] ct_addr [11] = '{11'h000, 11'h100, 11'h101, 11'h200, 11'h201, 11'h100, 11'h101, 11'h200, 11'h201, 11'h000, 11'h000};
  logic [1:0]  ct_rv   [11] = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10, 2'b00};
  logic [10:0] wrap_addr [4] = '{11'h7FE, 11'h7FF, 11'h000, 11'h001};

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    cmd_valid = 2'b11;
    cmd_write = 2'b00;
    cmd_addr[0] = 11'h100; cmd_addr[1] = 11'h200;
    cmd_len[0] = 4'd1;     cmd_len[1] = 4'd1;
    wdata = '0;
    wbe = '0;

    // ---- reset values, requests held through reset ----
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready",  256'(cmd_ready), 256'(2'b00));
    check("rst_wready", 256'(wdata_ready), 256'(2'b00));
    check("rst_rvalid", 256'(rvalid), 256'(2'b00));
    check("rst_cs",     256'(mem_chipselect), 256'(0));
    check("rst_write",  256'(mem_write), 256'(0));
    check("rst_addr",   256'(mem_address), 256'(0));
    check("rst_wdata",  mem_writedata, 256'(0));
    check("rst_be",     256'(mem_byteenable), 256'(0));
    check("rst_clken",  256'(mem_clken), 256'(0));
    check("rst_state",  256'(dbg_state), 256'(ST_IDLE));
    reset = 1'b0;
    @(negedge clk);
    check("rel_ready", 256'(cmd_ready), 256'(2'b00));
    step();
    check("clken_on", 256'(mem_clken), 256'(1));

    // ---- contention: r0 first, then alternation with zero gap ----
    exp_q.push_back(rd_pat(11'h100)); exp_q.push_back(rd_pat(11'h101));
    exp_q.push_back(rd_pat(11'h200)); exp_q.push_back(rd_pat(11'h201));
    exp_q.push_back(rd_pat(11'h100)); exp_q.push_back(rd_pat(11'h101));
    exp_q.push_back(rd_pat(11'h200)); exp_q.push_back(rd_pat(11'h201));
    for (int c = 0; c < 11; c++) begin
      if (c == 8) cmd_valid = 2'b00;
      @(negedge clk);
      check($sformatf("ct_rdy%0d", c), 256'(cmd_ready), 256'(ct_rdy[c]));
      check($sformatf("ct_cs%0d", c), 256'(mem_chipselect), 256'(ct_cs[c]));
      if (ct_cs[c]) check($sformatf("ct_addr%0d", c), 256'(mem_address), 256'(ct_addr[c]));
      check($sformatf("ct_rv%0d", c), 256'(rvalid), 256'(ct_rv[c]));
      step();
    end

    // ---- single read: r0 addr 0x010 len 3 ----
    do_reset();
    for (int k = 0; k < 4; k++) exp_q.push_back(rd_pat(11'(k + 16)));
    cmd_valid = 2'b01; cmd_write = 2'b00; cmd_addr[0] = 11'h010; cmd_len[0] = 4'd3;
    for (int c = 0; c < 7; c++) begin
      if (c == 1) cmd_valid = 2'b00;
      @(negedge clk);
      check($sformatf("rd_rdy%0d", c), 256'(cmd_ready), 256'((c == 0) ? 2'b01 : 2'b00));
      if (c >= 1 && c <= 4) begin
        check($sformatf("rd_addr%0d", c), 256'(mem_address), 256'(11'(c + 15)));
        check($sformatf("rd_cs%0d", c), 256'(mem_chipselect), 256'(1));
        check($sformatf("rd_we%0d", c), 256'(mem_write), 256'(0));
        check($sformatf("rd_be%0d", c), 256'(mem_byteenable), 256'(32'hFFFF_FFFF));
        check($sformatf("rd_st%0d", c), 256'(dbg_state), 256'(ST_BURST));
      end else begin
        check($sformatf("rd_cs%0d", c), 256'(mem_chipselect), 256'(0));
        check($sformatf("rd_st%0d", c), 256'(dbg_state), 256'(ST_IDLE));
      end
      check($sformatf("rd_rv%0d", c), 256'(rvalid), 256'((c >= 2 && c <= 5) ? 2'b01 : 2'b00));
      step();
    end

    // ---- write with address wrap: r1 addr 0x7FE len 3 ----
    do_reset();
    cmd_valid = 2'b10; cmd_write = 2'b10; cmd_addr[1] = 11'h7FE; cmd_len[1] = 4'd3;
    wdata[1] = wd_pat(0); wbe[1] = be_pat(0);
    @(negedge clk);
    check("wr_rdy", 256'(cmd_ready), 256'(2'b10));
    check("wr_wready0", 256'(wdata_ready), 256'(2'b10));
    step();
    cmd_valid = 2'b00;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 3) begin
        wdata[1] = wd_pat(k);
        wbe[1] = be_pat(k);
      end
      @(negedge clk);
      check($sformatf("wr_wready%0d", k), 256'(wdata_ready), 256'((k <= 3) ? 2'b10 : 2'b00));
      if (k <= 4) begin
        check($sformatf("wr_addr%0d", k), 256'(mem_address), 256'(wrap_addr[k-1]));
        check($sformatf("wr_we%0d", k), 256'(mem_write), 256'(1));
        check($sformatf("wr_data%0d", k), mem_writedata, wd_pat(k - 1));
        check($sformatf("wr_be%0d", k), 256'(mem_byteenable), 256'(be_pat(k - 1)));
      end else begin
        check("wr_cs_end", 256'(mem_chipselect), 256'(0));
        check("wr_we_end", 256'(mem_write), 256'(0));
      end
      step();
    end

    // ---- reset at beat 2 of an 8-beat read ----
    do_reset();
    exp_q.push_back(rd_pat(11'h040));
    cmd_valid = 2'b01; cmd_write = 2'b00; cmd_addr[0] = 11'h040; cmd_len[0] = 4'd7;
    @(negedge clk);
    check("mr_rdy", 256'(cmd_ready), 256'(2'b01));
    step();
    cmd_valid = 2'b00;
    step();
    step();
    check("mr_beat2", 256'(mem_address), 256'(11'h042));
    #1;
    cmd_valid = 2'b10; cmd_write = 2'b10;
    reset = 1'b1;
    #1;
    check("mr_state",  256'(dbg_state), 256'(ST_IDLE));
    check("mr_cs",     256'(mem_chipselect), 256'(0));
    check("mr_addr",   256'(mem_address), 256'(0));
    check("mr_be",     256'(mem_byteenable), 256'(0));
    check("mr_clken",  256'(mem_clken), 256'(0));
    check("mr_rvalid", 256'(rvalid), 256'(0));
    check("mr_ready",  256'(cmd_ready), 256'(2'b00));
    check("mr_wready", 256'(wdata_ready), 256'(2'b00));
    @(negedge clk);
    cmd_valid = 2'b00; cmd_write = 2'b00;
    reset = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      @(negedge clk);
      check($sformatf("mr_post_cs%0d", c), 256'(mem_chipselect), 256'(0));
      check($sformatf("mr_post_rv%0d", c), 256'(rvalid), 256'(0));
    end

`ifdef MEMC_ARB_STATS_EN
    // ---- beat statistics: 3 x 16-beat bursts from r0, then clear ----
    begin
      int n_acc;
      bit idle_seen;
      do_reset();
      n_acc = 0;
      cmd_valid = 2'b01; cmd_write = 2'b00; cmd_addr[0] = 11'h000; cmd_len[0] = 4'd15;
      for (int c = 0; c < 200 && n_acc < 3; c++) begin
        @(negedge clk);
        if (cmd_ready[0]) n_acc++;
        step();
        if (n_acc == 3) cmd_valid = 2'b00;
      end
      cmd_valid = 2'b00;
      check("st_accepts", 256'(n_acc), 256'(3));
      idle_seen = 1'b0;
      for (int c = 0; c < 60 && !idle_seen; c++) begin
        @(negedge clk);
        if (!mem_chipselect) idle_seen = 1'b1;
        else step();
      end
      check("st_idle", 256'(mem_chipselect), 256'(0));
      check("st_beats0_48", 256'(stat_beats0), 256'(48));
      check("st_beats1_0", 256'(stat_beats1), 256'(0));
      exp_q.delete();
      for (int k = 0; k < 4; k++) exp_q.push_back(rd_pat(11'(k + 32)));
      step();
      cmd_valid = 2'b01; cmd_addr[0] = 11'h020; cmd_len[0] = 4'd3;
      @(negedge clk);
      check("st_rdy", 256'(cmd_ready), 256'(2'b01));
      step();
      cmd_valid = 2'b00;
      stat_clear = 1'b1;
      @(negedge clk);
      check("st_clr_beat", 256'(mem_chipselect), 256'(1));
      step();
      stat_clear = 1'b0;
      check("st_cleared", 256'(stat_beats0), 256'(0));
      repeat (6) step();
      check("st_after_clr", 256'(stat_beats0), 256'(3));
    end
`endif

    repeat (3) step();
    check("exp_q_empty", 256'(exp_q.size()), 256'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/memc_port_arbiter.md
MEMC_PORT_ARBITER -- requirements
Module: memc_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 11, word address width of the 256-bit matrix-C memory port.
REQ-002 SHALL have parameter DATA_W, 256, data width; BE_W = DATA_W/8.
REQ-003 SHALL have parameter LEN_W, 4, burst-length field width; beats = cmd_len+1, 1..16.
REQ-004 SHALL have one clock and an asynchronous, active-high reset, named as in the codebase:
- clk  in  1  sole clock.
- reset  in  1  async active-high reset.
REQ-005 SHALL have these requester ports, index i in {0,1}:
- cmd_valid  in  2  burst request per requester.
- cmd_ready  out  2  burst accepted this cycle.
- cmd_write  in  2  1 = write burst, 0 = read burst.
- cmd_addr  in  2xADDR_W  start word address.
- cmd_len  in  2xLEN_W  beats minus one.
- wdata  in  2xDATA_W  write beat data.
- wbe  in  2xBE_W  write beat byte enables.
- wdata_ready  out  2  beat sampled this cycle.
- rdata  out  DATA_W  read return data, shared.
- rvalid  out  2  rdata valid for requester i.
REQ-006 SHALL have these memory ports, all registered:
- mem_address  out  ADDR_W.
- mem_chipselect  out  1.
- mem_write  out  1.
- mem_writedata  out  DATA_W.
- mem_byteenable  out  BE_W.
- mem_clken  out  1  constant 1 after reset.
- mem_readdata  in  DATA_W  unregistered RAM output, valid the cycle after the address.

Function
REQ-007 SHALL use FSM IDLE/BURST; IDLE->BURST on acceptance; BURST->IDLE after the last beat unless a new command is accepted in that cycle.
REQ-008 SHALL accept at most one command per cycle; cmd_ready[i] asserts only in IDLE or in the last-beat cycle of BURST, for the arbitration winner with cmd_valid[i]=1.
REQ-009 SHALL arbitrate round-robin: when both are valid, the winner is the requester not granted most recently; a single valid requester always wins.
REQ-010 SHALL issue beat k of a burst accepted in cycle T on the memory port in cycle T+1+k, for k=0..cmd_len, with no bubbles; back-to-back bursts SHALL have zero idle cycles.
REQ-011 SHALL compute beat addresses as cmd_addr+k modulo 2^ADDR_W, so 2047 wraps to 0.
REQ-012 SHALL assert wdata_ready[i] in cycles T..T+cmd_len of a write burst and register wdata/wbe onto mem_writedata/mem_byteenable the next cycle.
REQ-013 SHALL drive mem_write=0 and mem_byteenable all-ones for read beats.
REQ-014 SHALL assert rvalid[i] with rdata=mem_readdata one cycle after each read beat (T+2+k) and route it to the owning requester only.
REQ-015 SHALL drive mem_chipselect=0 and mem_write=0 in idle cycles.
REQ-016 SHALL allow cmd_valid to deassert before acceptance without effect.

Reset
REQ-017 SHALL, on reset assertion, immediately set state=IDLE, cmd_ready=0, wdata_ready=0, rvalid=0, mem_chipselect=0, mem_write=0, mem_address=0, mem_writedata=0, mem_byteenable=0, mem_clken=0, and the round-robin pointer to favour requester 0.
REQ-018 SHALL discard any in-flight burst on reset with no partial completion after release; the first command is accepted no earlier than the first clk edge after deassertion.

Configuration
REQ-019 SHALL, with MEMC_ARB_STATS_EN defined, add input stat_clear and outputs stat_beats0/stat_beats1 (32 bits each) counting issued beats per requester, saturating at 0xFFFFFFFF, cleared by reset or stat_clear (clear wins over a same-cycle increment).
REQ-020 SHALL, without MEMC_ARB_STATS_EN, omit those ports and counters; all other behaviour is identical.

Structure
REQ-021 SHALL place ADDR_W/DATA_W/LEN_W defaults and the state enum in package memc_arb_pkg.
REQ-022 SHALL implement the 2-way round-robin pick as sub-module memc_rr_pick.

Verification
REQ-023 SHALL verify a single read: r0 addr 0x010, len 3 at T -> mem_address 0x010..0x013 in T+1..T+4; rvalid[0] in T+2..T+5.
REQ-024 SHALL verify a simultaneous request after reset: r0 and r1 both valid -> r0 granted first, then r1 with zero gap; repeated contention alternates grants.
REQ-025 SHALL verify wrap: write r1 addr 0x7FE, len 3 -> addresses 0x7FE, 0x7FF, 0x000, 0x001 with matching wdata beats.
REQ-026 SHALL verify reset mid-burst at beat 2 of 8 -> all outputs reach reset values immediately; no further beats or rvalid after release.
REQ-027 SHALL verify, with MEMC_ARB_STATS_EN, 3 bursts of 16 beats from r0 -> stat_beats0=48; stat_clear in the same cycle as a beat -> 0.
